// File: rtl/psum_requant_pkg.sv
// Shared definitions for the product accumulate / requantize slice.
// Holds the default widths, the FSM state encoding and the saturation bounds
// derived from the output feature width.
package psum_requant_pkg;

  localparam int unsigned P_WIDTH_DEF = 16;
  localparam int unsigned A_WIDTH_DEF = 24;
  localparam int unsigned O_WIDTH_DEF = 8;
  localparam int unsigned S_WIDTH_DEF = 5;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Largest / smallest two's-complement value representable in ow bits.
  function automatic longint sat_max(input int unsigned ow);
    return (longint'(1) <<< (ow - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned ow);
    return -(longint'(1) <<< (ow - 1));
  endfunction

  localparam longint SAT_MAX_DEF = sat_max(O_WIDTH_DEF);
  localparam longint SAT_MIN_DEF = sat_min(O_WIDTH_DEF);

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: arithmetic right shift of a wide signed sum,
// optional round-half-up (ACCUM_ROUND_EN), then saturation to O_WIDTH.
// Ports:
//   sum    in  A_WIDTH  signed accumulated sum
//   shift  in  S_WIDTH  right-shift amount
//   data_c out O_WIDTH  signed saturated result
//   sat_c  out 1        result was clipped
// Macro ACCUM_ROUND_EN: add 2^(k-1) before shifting (k > 0).
module requant_sat
  import psum_requant_pkg::*;
#(
  parameter int unsigned A_WIDTH = A_WIDTH_DEF,
  parameter int unsigned O_WIDTH = O_WIDTH_DEF,
  parameter int unsigned S_WIDTH = S_WIDTH_DEF
) (
  input  logic signed [A_WIDTH-1:0] sum,
  input  logic        [S_WIDTH-1:0] shift,
  output logic signed [O_WIDTH-1:0] data_c,
  output logic                      sat_c
);

  localparam logic signed [A_WIDTH:0] HI = (A_WIDTH+1)'(sat_max(O_WIDTH));
  localparam logic signed [A_WIDTH:0] LO = (A_WIDTH+1)'(sat_min(O_WIDTH));

  logic signed [A_WIDTH:0] ext;
  logic signed [A_WIDTH:0] rnd;
  logic signed [A_WIDTH:0] shr;
  logic                    big;

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    ext = {sum[A_WIDTH-1], sum};
    big = (32'(shift) >= A_WIDTH);
    rnd = ext;
`ifdef ACCUM_ROUND_EN
    if ((shift != '0) && !big) begin
      rnd = ext + ((A_WIDTH+1)'(1) << (shift - S_WIDTH'(1)));
    end
`endif
    // Shifts at or beyond the sum width collapse to the sign.
    if (big) begin
      shr = ext[A_WIDTH] ? '1 : '0;
    end else begin
      shr = rnd >>> shift;
    end

    data_c = O_WIDTH'(shr);
    sat_c  = 1'b0;
    if (shr > HI) begin
      data_c = O_WIDTH'(HI);
      sat_c  = 1'b1;
    end else if (shr < LO) begin
      data_c = O_WIDTH'(LO);
      sat_c  = 1'b1;
    end
  end

endmodule

// File: rtl/psum_requant_acc.sv
// Accumulates groups of signed products (closed by a last flag) into a wide
// wrapping accumulator, then shifts and saturates each group sum back to
// feature width and presents it on a registered valid/ready output.
// Ports:
//   clk_i, reset_i                 clock, async active-high reset
//   prod_valid_i/prod_ready_o      product beat handshake
//   prod_data_i, prod_last_i       signed product, end-of-group flag
//   shift_i                        shift amount, used on the last beat
//   out_valid_o/out_ready_i        result handshake
//   out_data_o, sat_o              requantized result and clip flag
// Macro ACCUM_ROUND_EN: round half up instead of truncating (see requant_sat).
module psum_requant_acc
  import psum_requant_pkg::*;
#(
  parameter int unsigned P_WIDTH = P_WIDTH_DEF,
  parameter int unsigned A_WIDTH = A_WIDTH_DEF,
  parameter int unsigned O_WIDTH = O_WIDTH_DEF,
  parameter int unsigned S_WIDTH = S_WIDTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      prod_valid_i,
  output logic                      prod_ready_o,
  input  logic signed [P_WIDTH-1:0] prod_data_i,
  input  logic                      prod_last_i,
  input  logic        [S_WIDTH-1:0] shift_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic signed [O_WIDTH-1:0] out_data_o,
  output logic                      sat_o
);

  state_t                    state_q, state_d;
  logic signed [A_WIDTH-1:0] acc_q, acc_d;
  logic signed [A_WIDTH-1:0] prod_ext;
  logic signed [A_WIDTH-1:0] sum_c;
  logic                      beat;
  logic                      emit;
  logic signed [O_WIDTH-1:0] rq_data;
  logic                      rq_sat;

  // Every beat stalls while an unconsumed result is held.
  assign prod_ready_o = !out_valid_o || out_ready_i;
  assign beat         = prod_valid_i && prod_ready_o;
  assign prod_ext     = A_WIDTH'(prod_data_i);
  assign sum_c        = (state_q == ACC) ? acc_q + prod_ext : prod_ext;

  // State and accumulator registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state: a last beat always closes the group and returns to IDLE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    emit    = 1'b0;
    if (beat) begin
      if (prod_last_i) begin
        emit    = 1'b1;
        acc_d   = '0;
        state_d = IDLE;
      end else begin
        acc_d   = sum_c;
        state_d = ACC;
      end
    end
  end

  requant_sat #(
    .A_WIDTH(A_WIDTH),
    .O_WIDTH(O_WIDTH),
    .S_WIDTH(S_WIDTH)
  ) u_requant_sat (
    .sum   (sum_c),
    .shift (shift_i),
    .data_c(rq_data),
    .sat_c (rq_sat)
  );

  // Output register; an emit on a transfer cycle reloads without a bubble.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      sat_o       <= 1'b0;
    end else if (emit) begin
      out_valid_o <= 1'b1;
      out_data_o  <= rq_data;
      sat_o       <= rq_sat;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/psum_requant_acc.md
Name: psum_requant_acc

Overview:
Consumer end of the signed multiplier datapath. It accepts a stream of full-width signed products, accumulates each group (delimited by a last flag) into a wide accumulator, then arithmetic-shifts and saturates the sum back to feature width. The result is presented on a valid/ready output toward the next PE stage or the output buffer. It narrows I+F-bit products back to I-bit features.

Parameters:
P_WIDTH, 16, product input width (I_WIDTH + F_WIDTH)
A_WIDTH, 24, accumulator width; must be >= P_WIDTH
O_WIDTH, 8, output feature width
S_WIDTH, 5, shift-amount width

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous, active-high reset
prod_valid_i  in  1  product beat valid
prod_ready_o  out  1  product beat accepted when valid and ready both high
prod_data_i  in  P_WIDTH  signed product
prod_last_i  in  1  final beat of the current group
shift_i  in  S_WIDTH  right-shift amount, sampled on the accepted last beat
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream ready
out_data_o  out  O_WIDTH  signed requantized result
sat_o  out  1  result was clipped; qualified by out_valid_o

Behaviour:
- Reset (async, reset_i=1): acc=0, state=IDLE, out_valid_o=0, out_data_o=0, sat_o=0. Reset mid-group discards the partial sum.
- Product is sign-extended to A_WIDTH. The accumulator wraps modulo 2^A_WIDTH with no overflow flag.
- FSM states:
  - IDLE: acc=0. A non-last beat: acc<=prod, go to ACC. A last beat: emit result, stay in IDLE.
  - ACC: a non-last beat: acc<=acc+prod. A last beat: emit result from acc+prod, acc<=0, go to IDLE.
- Emit: out_data_o and sat_o are registered. out_valid_o rises on the cycle after the accepted last beat (latency 1). Back-to-back groups run with no bubble.
- Requant on sum s with shift k:
  - r = s >>> k (arithmetic). If k >= A_WIDTH, r = 0 or -1 according to sign.
  - Saturate r to [-2^(O_WIDTH-1), 2^(O_WIDTH-1)-1]. sat_o=1 iff clipped.
- prod_ready_o = !out_valid_o || out_ready_i (combinational from out_ready_i).
  - This applies to every beat, not only last beats, so no beat is lost and the accumulator holds while stalled.
- Output handshake: out_valid_o stays high and data stays stable until out_ready_i. A transfer and a new emit on the same cycle reloads the register and keeps out_valid_o high.
- Input rules: prod_data_i and shift_i are ignored when no beat is accepted. shift_i has no effect on non-last beats.

Optional Feature:
ACCUM_ROUND_EN
- Defined: round half up before the shift: r = (s + 2^(k-1)) >>> k for k > 0. The add is performed at A_WIDTH+1 bits so it cannot wrap. k=0 is unchanged.
- Undefined: truncation (floor) via the plain arithmetic shift.

Decomposition:
- Shared package psum_requant_pkg holds:
  - default widths
  - FSM state enum (IDLE, ACC)
  - saturation bound constants derived from O_WIDTH
- One sub-module, requant_sat: combinational shift, optional round, saturate, and sat flag. It is instantiated once on the emit path.

Test Plan:
- Beats 100, 200, -50(last), shift=2, out_ready=1 -> out_valid one cycle after last, out_data=62, sat=0.
- Beats 30000, 30000(last), shift=4 -> out=127, sat=1. Single beat -30000(last), shift=0 -> out=-128, sat=1.
- Back-pressure: group A = 5(last), out_ready=0, then group B = 7, 9(last) -> prod_ready low from the cycle after A's emit. out holds 5. Raise out_ready -> 5 transfers, then 16 is emitted. No beat is lost.
- Reset mid-group: beats 50, 50, pulse reset_i, then 10(last), shift=0 -> out=10, out_valid=0 during reset.
- Rounding with sums 6 and -6, shift=2 -> without macro: 1 and -2. With ACCUM_ROUND_EN: 2 and -1.
- Throughput: single-beat groups 1, 2, 3, 4 on consecutive cycles, out_ready=1 -> outputs 1, 2, 3, 4 on consecutive cycles, prod_ready constantly 1. shift=31 with sum -7 -> out=-1.
